result_writeback: RTL and testbench

- Downstream neighbour of the scratchpad→systolic-array integration stage.
- Captures one N-lane FP32 result vector from the systolic array when the array flags it valid.
- Serialises the vector into an output scratchpad (SPAD_Y, OpenRAM sram_0rw1r1w_32_64_freepdk45 write port0), one word per write slot at base_addr + lane.
- Pulses done when the last word is written, and reports dropped vectors via a sticky overrun flag.

---
 rtl/systolic_array_pkg.sv | 20 ++
 rtl/result_writeback.sv | 163 ++++++++++++++++
 tb/tb_result_writeback.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_pkg.sv
// Shared types and helpers for the systolic-array result path.
// Optional feature macro: WB_RELU_EN (enables relu_fp32 at result capture).
package systolic_array_pkg;

  localparam int unsigned FP_DW       = 32;
  localparam int unsigned FP_SIGN_BIT = FP_DW - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  // Clamp any word with the sign bit set (negatives, -0, signed NaN) to +0.
  function automatic logic [FP_DW-1:0] relu_fp32(input logic [FP_DW-1:0] w);
    return w[FP_SIGN_BIT] ? '0 : w;
  endfunction

endpackage

// File: rtl/result_writeback.sv
// Captures one N-lane result vector and serialises it into SPAD_Y port0.
// Optional feature macro: WB_RELU_EN (clamp sign-set lanes to zero at capture).
module result_writeback
  import systolic_array_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned AW     = 6,
  parameter int unsigned DW     = 32,
  parameter int unsigned WR_GAP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  y_valid_i,
  input  logic [N-1:0][DW-1:0]  y_in,
  input  logic [AW-1:0]         base_addr_y,
  input  logic                  clr_overrun_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overrun_o,
  output logic                  spad_y_csb0,
  output logic [AW-1:0]         spad_y_addr0,
  output logic [DW-1:0]         spad_y_din0
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GW = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((WR_GAP > 0) ? (WR_GAP - 1) : 0);

  wb_state_t            state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [N-1:0][DW-1:0] vbuf_q, vbuf_d, cap_c;
  logic [AW-1:0]        base_q, base_d;

  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic                 csb_q, csb_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        din_q, din_d;

`ifdef WB_RELU_EN
  // Capture path: clamp sign-set lanes to zero.
  always_comb begin
    for (int unsigned l = 0; l < N; l++) begin
      cap_c[l] = DW'(relu_fp32(FP_DW'(y_in[l])));
    end
  end
`else
  // Capture path: bit-exact pass-through.
  assign cap_c = y_in;
`endif

  // State register plus vector buffer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      vbuf_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      vbuf_q  <= vbuf_d;
      base_q  <= base_d;
    end
  end

  // Next-state: capture in IDLE, step lanes through WRITE/GAP, one DONE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    vbuf_d  = vbuf_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (y_valid_i) begin
          vbuf_d  = cap_c;
          base_d  = base_addr_y;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
          if (WR_GAP > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = WRITE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    csb_d     = (state_d != WRITE);
    addr_d    = addr_q;
    din_d     = din_q;
    overrun_d = overrun_q;
    if (state_d == WRITE) begin
      addr_d = base_d + AW'(idx_d);
      din_d  = vbuf_d[idx_d];
    end
    if (y_valid_i && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (clr_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      csb_q     <= 1'b1;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      csb_q     <= csb_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  assign ready_o      = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overrun_o    = overrun_q;
  assign spad_y_csb0  = csb_q;
  assign spad_y_addr0 = addr_q;
  assign spad_y_din0  = din_q;

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: two instances (WR_GAP=0 and WR_GAP=3) checked
// cycle by cycle against a latency/timeline model and a behavioural SPAD_Y.
// Honours WB_RELU_EN when defined for the build.
module tb_result_writeback;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a  [2];
  logic          vld_a  [2];
  logic          clr_a  [2];
  vec_t          y_a    [2];
  logic [AW-1:0] base_a [2];
  logic          rdy [2];
  logic          bsy [2];
  logic          dn  [2];
  logic          ovr [2];
  logic          csb [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] din  [2];

  logic [DW-1:0] mem [2][64];

  int checks = 0;
  int errors = 0;
  bit            ovr_exp   [2];
  logic [AW-1:0] last_addr [2];
  logic [DW-1:0] last_din  [2];

  result_writeback #(.N(N), .AW(AW), .DW(DW), .WR_GAP(0)) dut0 (
    .clk(clk), .rst(rst_a[0]), .y_valid_i(vld_a[0]), .y_in(y_a[0]),
    .base_addr_y(base_a[0]), .clr_overrun_i(clr_a[0]),
    .ready_o(rdy[0]), .busy_o(bsy[0]), .done_o(dn[0]), .overrun_o(ovr[0]),
    .spad_y_csb0(csb[0]), .spad_y_addr0(addr[0]), .spad_y_din0(din[0])
  );

  result_writeback #(.N(N), .AW(AW), .DW(DW), .WR_GAP(3)) dut1 (
    .clk(clk), .rst(rst_a[1]), .y_valid_i(vld_a[1]), .y_in(y_a[1]),
    .base_addr_y(base_a[1]), .clr_overrun_i(clr_a[1]),
    .ready_o(rdy[1]), .busy_o(bsy[1]), .done_o(dn[1]), .overrun_o(ovr[1]),
    .spad_y_csb0(csb[1]), .spad_y_addr0(addr[1]), .spad_y_din0(din[1])
  );

  // Behavioural SPAD_Y write port.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (csb[d] === 1'b0) mem[d][addr[d]] <= din[d];
    end
  end

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Expected stored word: with ReLU, any negative (as signed integer) becomes 0.
  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] x);
`ifdef WB_RELU_EN
    return ($signed(x) < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < N; j++) v[j] = DW'($urandom);
    return v;
  endfunction

  // One vector on instance d; optional extra valid, clear pulse and reset pulse.
  task automatic test_vector(input string name, input int d, input vec_t v,
                             input logic [AW-1:0] b, input int ovr_cyc,
                             input int clr_cyc, input int rst_cyc);
    int s, dc, k, i;
    bit aborted;
    logic e_rdy, e_bsy, e_dn, e_csb;
    logic [DW-1:0] w [N];
    logic [42:0] got, exp;
    logic [AW-1:0] a;
    s = gap_of(d) + 1;
    dc = 2 + (N - 1) * s;
    aborted = 1'b0;
    for (int j = 0; j < N; j++) w[j] = ref_word(v[j]);
    for (int t = 0; t <= dc; t++) begin
      if (aborted || t == 0) begin
        e_rdy = 1; e_bsy = 0; e_dn = 0; e_csb = 1;
      end else if (t == dc) begin
        e_rdy = 0; e_bsy = 1; e_dn = 1; e_csb = 1;
      end else begin
        e_rdy = 0; e_bsy = 1; e_dn = 0;
        k = t - 1;
        e_csb = ((k % s) != 0);
        if (!e_csb) begin
          i = k / s;
          last_addr[d] = b + AW'(i);
          last_din[d]  = w[i];
        end
      end
      got = {rdy[d], bsy[d], dn[d], ovr[d], csb[d], addr[d], din[d]};
      exp = {e_rdy, e_bsy, e_dn, logic'(ovr_exp[d]), e_csb, last_addr[d], last_din[d]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s dut%0d cyc%0d {rdy,bsy,done,ovr,csb,addr,din} got %h exp %h",
                 name, d, t, got, exp);
      end
      vld_a[d] = 0; clr_a[d] = 0; rst_a[d] = 0;
      y_a[d] = rand_vec();
      base_a[d] = AW'($urandom);
      if (t == 0) begin vld_a[d] = 1; y_a[d] = v; base_a[d] = b; end
      if (t == ovr_cyc) vld_a[d] = 1;
      if (t == clr_cyc) clr_a[d] = 1;
      if (t == rst_cyc) rst_a[d] = 1;
      if (t == rst_cyc) begin
        ovr_exp[d] = 0; last_addr[d] = '0; last_din[d] = '0; aborted = 1'b1;
      end else if (vld_a[d] && !e_rdy) begin
        ovr_exp[d] = 1;
      end else if (clr_a[d]) begin
        ovr_exp[d] = 0;
      end
      @(posedge clk); #1;
    end
    vld_a[d] = 0; clr_a[d] = 0; rst_a[d] = 0;
    if (rst_cyc < 0) begin
      for (int j = 0; j < N; j++) begin
        a = b + AW'(j);
        checks++;
        if (mem[d][a] !== w[j]) begin
          errors++;
          $display("FAIL %s_readback dut%0d lane%0d got %h exp %h", name, d, j, mem[d][a], w[j]);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [42:0] got;
    for (int d = 0; d < 2; d++) begin
      rst_a[d] = 1; vld_a[d] = 0; clr_a[d] = 0; y_a[d] = '0; base_a[d] = '0;
      ovr_exp[d] = 0; last_addr[d] = '0; last_din[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      rst_a[d] = 0;
      got = {rdy[d], bsy[d], dn[d], ovr[d], csb[d], addr[d], din[d]};
      checks++;
      if (got !== {5'b10001, 38'h0}) begin
        errors++;
        $display("FAIL reset dut%0d got %h exp %h", d, got, {5'b10001, 38'h0});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    vec_t v;
    logic [DW-1:0] rd;
    v = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    test_vector("basic", 0, v, 6'h10, -1, -1, -1);
    rd = mem[0][6'h10];
    checks++;
    if (rd !== 32'h3F800000) begin
      errors++;
      $display("FAIL basic_lane0 got %h exp %h", rd, 32'h3F800000);
    end
    rd = mem[0][6'h13];
    checks++;
    if (rd !== 32'h40800000) begin
      errors++;
      $display("FAIL basic_lane3 got %h exp %h", rd, 32'h40800000);
    end
  endtask

  task automatic test_gap();
    vec_t v;
    v = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    test_vector("gap", 1, v, 6'h10, -1, -1, -1);
  endtask

  task automatic test_wrap();
    test_vector("wrap0", 0, rand_vec(), 6'h3E, -1, -1, -1);
    test_vector("wrap1", 1, rand_vec(), 6'h3E, -1, -1, -1);
  endtask

  task automatic test_overrun();
    test_vector("ovr_clr", 0, rand_vec(), 6'h20, 2, 4, -1);
    test_vector("ovr_setwins", 1, rand_vec(), 6'h05, 3, 3, -1);
    test_vector("ovr_clear_late", 1, rand_vec(), 6'h09, -1, 2, -1);
  endtask

  task automatic test_abort();
    test_vector("abort0", 0, rand_vec(), 6'h30, 1, -1, 2);
    test_vector("after_abort0", 0, rand_vec(), 6'h31, -1, -1, -1);
    test_vector("abort1", 1, rand_vec(), 6'h12, -1, -1, 6);
    test_vector("after_abort1", 1, rand_vec(), 6'h13, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    test_vector("b2b_first0", 0, rand_vec(), 6'h08, 2 + (N - 1) * 1, -1, -1);
    test_vector("b2b_second0", 0, rand_vec(), 6'h28, -1, 1, -1);
    test_vector("b2b_first1", 1, rand_vec(), 6'h18, 2 + (N - 1) * 4, -1, -1);
    test_vector("b2b_second1", 1, rand_vec(), 6'h38, -1, 1, -1);
  endtask

  task automatic test_relu();
    vec_t v;
    logic [DW-1:0] rd, e;
    v = {32'hFFC00000, 32'h7FC00000, 32'hBF800000, 32'h80000000};
    test_vector("relu", 0, v, 6'h00, -1, -1, -1);
`ifdef WB_RELU_EN
    e = 32'h00000000;
`else
    e = 32'hBF800000;
`endif
    rd = mem[0][6'h01];
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL relu_lane1 got %h exp %h", rd, e);
    end
    rd = mem[0][6'h02];
    checks++;
    if (rd !== 32'h7FC00000) begin
      errors++;
      $display("FAIL relu_lane2 got %h exp %h", rd, 32'h7FC00000);
    end
  endtask

  task automatic test_random();
    int d, dc, oc, cc;
    for (int n = 0; n < 20; n++) begin
      d  = int'($urandom_range(0, 1));
      dc = 2 + (N - 1) * (gap_of(d) + 1);
      oc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, dc)) : -1;
      cc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, dc)) : -1;
      test_vector("random", d, rand_vec(), AW'($urandom), oc, cc, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_wrap();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_relu();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
